// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shift-register command sequencer:
// command op encodings, FSM state type and default widths.
package shift_cmd_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 3;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_SHR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      FIN   = 2'b11
   } state_e;

endpackage

// File: rtl/shift_cmd_seq.sv
// Command sequencer for a universal shift register. Accepts LOAD/SHIFT
// commands over valid/ready and expands them into single-cycle ld/sl/sr
// strobes, finishing with a one-cycle done pulse. All outputs are flops.
// Optional build macro SHIFT_CMD_SEQ_ROTATE_EN: serial input is taken from
// the fed-back register value (rotate) instead of the latched fill bit.
module shift_cmd_seq
   import shift_cmd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] q_fb,
   output logic             ld,
   output logic             sl,
   output logic             sr,
   output logic [WIDTH-1:0] D,
   output logic             D_sl,
   output logic             D_sr,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_q, ld_d;
   logic             sl_q, sl_d;
   logic             sr_q, sr_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             d_sl_q, d_sl_d;
   logic             d_sr_q, d_sr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept_s;
   logic             run_s;
   logic             left_s;
   logic             ser_s;
   logic             unused_s;

   assign accept_s = cmd_valid & (state_q == IDLE);

`ifdef SHIFT_CMD_SEQ_ROTATE_EN
   assign unused_s = fill_q;
`else
   assign unused_s = ^q_fb;
`endif

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      ld_d    = 1'b0;
      sl_d    = 1'b0;
      sr_d    = 1'b0;
      d_sl_d  = 1'b0;
      d_sr_d  = 1'b0;
      run_s   = 1'b0;
      left_s  = 1'b0;
      ser_s   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               op_d   = cmd_op;
               fill_d = cmd_fill;
               cnt_d  = cmd_cnt;
               case (cmd_op)
                  OP_LOAD: begin
                     state_d = LOAD;
                     ld_d    = 1'b1;
                     d_d     = cmd_data;
                  end
                  OP_SHL, OP_SHR: begin
                     if (cmd_cnt != {CNT_W{1'b0}}) begin
                        state_d = SHIFT;
                        run_s   = 1'b1;
                        left_s  = (cmd_op == OP_SHL);
`ifdef SHIFT_CMD_SEQ_ROTATE_EN
                        // Register is idle this cycle, so its current end bit is what wraps.
                        ser_s   = (cmd_op == OP_SHL) ? q_fb[WIDTH-1] : q_fb[0];
`else
                        ser_s   = cmd_fill;
`endif
                     end else begin
                        state_d = FIN;
                     end
                  end
                  default: begin
                     state_d = FIN;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            state_d = FIN;
         end
         SHIFT: begin
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
               state_d = FIN;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               run_s   = 1'b1;
               left_s  = (op_q == OP_SHL);
`ifdef SHIFT_CMD_SEQ_ROTATE_EN
               // The register shifts at this same edge, so pick the bit that
               // will sit at the wrapping end after that shift.
               ser_s   = (op_q == OP_SHL) ? q_fb[WIDTH-2] : q_fb[1];
`else
               ser_s   = fill_q;
`endif
            end
         end
         FIN: begin
            state_d = IDLE;
            op_d    = OP_NOP;
            fill_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (run_s) begin
         if (left_s) begin
            sl_d   = 1'b1;
            d_sl_d = ser_s;
         end else begin
            sr_d   = 1'b1;
            d_sr_d = ser_s;
         end
      end else begin
         sl_d = 1'b0;
         sr_d = 1'b0;
      end
   end

   assign busy_d = (state_d != IDLE);
   assign done_d = (state_d == FIN);

   // State, latched command, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         fill_q  <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         ld_q    <= 1'b0;
         sl_q    <= 1'b0;
         sr_q    <= 1'b0;
         d_q     <= {WIDTH{1'b0}};
         d_sl_q  <= 1'b0;
         d_sr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         d_q     <= d_d;
         d_sl_q  <= d_sl_d;
         d_sr_q  <= d_sr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign ld        = ld_q;
   assign sl        = sl_q;
   assign sr        = sr_q;
   assign D         = d_q;
   assign D_sl      = d_sl_q;
   assign D_sr      = d_sr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench for shift_cmd_seq driving a behavioural 4-bit universal shift
// register whose Q is fed back on q_fb.
module tb_shift_cmd_seq;
   import shift_cmd_pkg::*;

   localparam int W  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [W-1:0]  cmd_data = '0;
   logic [CW-1:0] cmd_cnt = '0;
   logic          cmd_fill = 1'b0;
   logic [W-1:0]  q_reg;
   logic          ld, sl, sr, D_sl, D_sr, busy, done;
   logic [W-1:0]  D;

   always #5 clk = ~clk;

   shift_cmd_seq #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
      .q_fb(q_reg), .ld(ld), .sl(sl), .sr(sr), .D(D), .D_sl(D_sl), .D_sr(D_sr),
      .busy(busy), .done(done)
   );

   // universal shift register model
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q_reg <= '0;
      else if (ld) q_reg <= D;
      else if (sl) q_reg <= {q_reg[W-2:0], D_sl};
      else if (sr) q_reg <= {D_sr, q_reg[W-1:1]};
   end

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  data;
      logic [CW-1:0] cnt;
      logic          fill;
      int            lat;
      int            nstrb;
   } vec_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] data;
      logic         fill;
      int           lat;
      int           nstrb;
      logic [W-1:0] q;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  acc_cyc = 0, prev_acc = 0, prev_lat = 0, strb = 0;
   bit  have_prev = 1'b0, b2b = 1'b0;
   logic [W-1:0] exp_q = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] q, input logic [1:0] op,
                                          input logic [W-1:0] data, input logic [CW-1:0] cnt,
                                          input logic fill);
      logic [W-1:0] r;
      r = q;
      if (op == OP_LOAD) r = data;
      else if (op == OP_SHL || op == OP_SHR) begin
         for (int i = 0; i < int'(cnt); i++) begin
`ifdef SHIFT_CMD_SEQ_ROTATE_EN
            if (op == OP_SHL) r = {r[W-2:0], r[W-1]};
            else              r = {r[0], r[W-1:1]};
`else
            if (op == OP_SHL) r = {r[W-2:0], fill};
            else              r = {fill, r[W-1:1]};
`endif
         end
      end
      return r;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // output monitor / scoreboard checker
   always @(negedge clk) begin
      if (rst_n) begin
         sb_t e;
         int  n;
         n = int'(ld) + int'(sl) + int'(sr);
         chk("strobe_onehot", (n <= 1) ? 32'd1 : 32'd0, 32'd1);
         chk("ready_vs_busy", cmd_ready, !busy);
         if (n != 0) begin
            strb++;
            if (sb.size() > 0) begin
               case (sb[0].op)
                  OP_LOAD: begin
                     chk("ld_strobe", ld, 1'b1);
                     chk("ld_data", D, sb[0].data);
                  end
                  OP_SHL: begin
                     chk("sl_strobe", sl, 1'b1);
                     chk("d_sr_during_sl", D_sr, 1'b0);
`ifndef SHIFT_CMD_SEQ_ROTATE_EN
                     chk("d_sl_fill", D_sl, sb[0].fill);
`endif
                  end
                  OP_SHR: begin
                     chk("sr_strobe", sr, 1'b1);
                     chk("d_sl_during_sr", D_sl, 1'b0);
`ifndef SHIFT_CMD_SEQ_ROTATE_EN
                     chk("d_sr_fill", D_sr, sb[0].fill);
`endif
                  end
                  default: chk("nop_strobe", n, 0);
               endcase
            end
         end else begin
            chk("d_sl_idle", D_sl, 1'b0);
            chk("d_sr_idle", D_sr, 1'b0);
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", done, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc - acc_cyc, e.lat);
               chk("strobe_count", strb, e.nstrb);
               chk("q_after", q_reg, e.q);
               chk("busy_in_fin", busy, 1'b1);
               prev_lat = e.lat;
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (b2b && have_prev) chk("b2b_spacing", cyc - prev_acc, prev_lat + 1);
            have_prev = 1'b1;
            prev_acc  = cyc;
            acc_cyc   = cyc;
            strb      = 0;
         end
      end
   end

   task automatic send(input vec_t v);
      sb_t e;
      bit  found;
      exp_q   = model(exp_q, v.op, v.data, v.cnt, v.fill);
      e.op    = v.op;
      e.data  = v.data;
      e.fill  = v.fill;
      e.lat   = v.lat;
      e.nstrb = v.nstrb;
      e.q     = exp_q;
      sb.push_back(e);
      cmd_op    = v.op;
      cmd_data  = v.data;
      cmd_cnt   = v.cnt;
      cmd_fill  = v.fill;
      cmd_valid = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) chk("ready_timeout", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[12];

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ld"}, ld, 1'b0);
      chk({tag, "_sl"}, sl, 1'b0);
      chk({tag, "_sr"}, sr, 1'b0);
      chk({tag, "_D"}, D, 4'b0000);
      chk({tag, "_D_sl"}, D_sl, 1'b0);
      chk({tag, "_D_sr"}, D_sr, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_ready"}, cmd_ready, 1'b1);
   endtask

   initial begin
      //            op       data     cnt   fill  lat strobes
      vecs[0]  = '{OP_LOAD, 4'b1010, 3'd0, 1'b0, 2, 1};
      vecs[1]  = '{OP_SHL,  4'b0000, 3'd2, 1'b1, 3, 2};
      vecs[2]  = '{OP_SHR,  4'b0000, 3'd0, 1'b1, 1, 0};
      vecs[3]  = '{OP_NOP,  4'b0000, 3'd0, 1'b0, 1, 0};
      vecs[4]  = '{OP_LOAD, 4'b0101, 3'd0, 1'b0, 2, 1};
      vecs[5]  = '{OP_SHR,  4'b0000, 3'd1, 1'b0, 2, 1};
      vecs[6]  = '{OP_SHL,  4'b0000, 3'd7, 1'b1, 8, 7};
      vecs[7]  = '{OP_SHR,  4'b1111, 3'd3, 1'b1, 4, 3};
      vecs[8]  = '{OP_LOAD, 4'b1100, 3'd0, 1'b1, 2, 1};
      vecs[9]  = '{OP_SHR,  4'b0000, 3'd5, 1'b0, 6, 5};
      vecs[10] = '{OP_SHL,  4'b0000, 3'd1, 1'b0, 2, 1};
      vecs[11] = '{OP_NOP,  4'b1111, 3'd7, 1'b1, 1, 0};

      // reset state
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // abandon a SHIFT cnt=5 in its second strobe cycle
      @(posedge clk); #1;
      cmd_op = OP_SHL; cmd_cnt = 3'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      chk("midrst_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("midrst_shift_started", sl, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      #1;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_ready_after", cmd_ready, 1'b1);
      chk("midrst_no_done", done, 1'b0);
      exp_q = '0;

      // command table, valid held high between commands
      @(posedge clk); #1;
      b2b = 1'b1;
      have_prev = 1'b0;
      for (int i = 0; i < 12; i++) send(vecs[i]);
      cmd_valid = 1'b0;
      b2b = 1'b0;

      // drain outstanding completions
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", sb.size(), 0);
      repeat (3) @(negedge clk);
      chk("idle_ready_end", cmd_ready, 1'b1);
      chk("idle_busy_end", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
Command sequencer directly upstream of the 4-bit universal shift register (ports sr, sl, ld, D_sr, D_sl, D, Q).
- Accepts load/shift commands over a valid/ready handshake.
- Expands each command into a cycle-exact sequence of single-cycle control strobes for the register.
- Reports completion with a one-cycle pulse.

Parameters:
WIDTH, 4, data width of the driven shift register
CNT_W, 3, width of the shift-count field (max count 2**CNT_W-1)

Ports:
clk  input  1  rising-edge clock, shared with the shift register
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00=NOP, 01=LOAD, 10=SHIFT_L, 11=SHIFT_R
cmd_data  input  WIDTH  parallel load word (LOAD only)
cmd_cnt  input  CNT_W  number of shift cycles (shift ops only)
cmd_fill  input  1  serial fill bit for shift ops
q_fb  input  WIDTH  register Q fed back (used only with ROTATE_EN)
ld  output  1  parallel-load strobe to register
sl  output  1  shift-left strobe
sr  output  1  shift-right strobe
D  output  WIDTH  parallel data to register
D_sl  output  1  serial input for left shift
D_sr  output  1  serial input for right shift
busy  output  1  command in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ld=sl=sr=0; D=0; D_sl=D_sr=0; busy=0; done=0; counter=0; latched command cleared. Takes effect immediately mid-command; an in-progress sequence is abandoned with no done pulse.
- All outputs are registered. At most one of ld/sl/sr is high in any cycle.
- cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready at a rising edge; op, data, cnt and fill are latched on accept.
- States: IDLE, LOAD, SHIFT, FIN.
- IDLE, on accept:
  - LOAD: go to LOAD.
  - SHIFT_L/SHIFT_R with cnt>0: go to SHIFT, counter=cnt.
  - NOP, or shift with cnt=0: go straight to FIN; no strobe is issued.
- LOAD: ld=1 and D=cmd_data for exactly one cycle, then FIN.
- SHIFT: the selected strobe (sl or sr) is high for exactly cnt consecutive cycles. D_sl (left) or D_sr (right) = cmd_fill during those cycles, 0 otherwise. The counter decrements each cycle; at counter==1 go to FIN.
- FIN: done=1 for one cycle, strobes low, then IDLE.
- busy = (state != IDLE), i.e. high from the cycle after accept through the FIN cycle.
- Latency from the accept edge:
  - LOAD: strobe in cycle 1, done in cycle 2.
  - Shift: strobes in cycles 1..cnt, done in cycle cnt+1.
  - NOP: done in cycle 1.
- Back-to-back commands: a new command is accepted in the first IDLE cycle after FIN, so the minimum command spacing is latency+1 cycles.
- Command inputs are ignored while cmd_ready=0.
- Between strobes: D holds the last loaded value; D_sl/D_sr return to 0.

Optional Feature:
SHIFT_CMD_SEQ_ROTATE_EN
- Defined: cmd_fill is ignored for shift ops. The serial input is taken from q_fb each cycle:
  - Left shift: D_sl=q_fb[WIDTH-1].
  - Right shift: D_sr=q_fb[0].
  - Result: a rotate by cnt positions.
- Undefined: q_fb is unused and serial fill comes from the latched cmd_fill.

Decomposition:
- Package shift_cmd_pkg holds:
  - Op encoding constants OP_NOP, OP_LOAD, OP_SHL, OP_SHR.
  - State enum typedef (IDLE, LOAD, SHIFT, FIN).
  - Default WIDTH and CNT_W.
- Single module. The down-counter is inline; no sub-module is warranted.
- The bench instantiates shift_cmd_seq driving the existing register, with q_fb tied to Q.

Test Plan:
- Reset mid-SHIFT (cnt=5, rst_n low in shift cycle 2) -> all outputs 0 immediately, no done, cmd_ready=1 after release.
- LOAD cmd_data=4'b1010 -> ld=1 one cycle with D=1010; done next cycle; register Q=1010.
- From Q=1010, SHIFT_L cnt=2 fill=1 -> sl high exactly 2 cycles with D_sl=1; Q=1011 after; done in cycle 3. With ROTATE_EN instead, Q=1010 after.
- SHIFT_R cnt=0 and NOP -> no ld/sl/sr, done in cycle 1, busy high 1 cycle.
- Back-to-back LOAD 0101 then SHIFT_R cnt=1 fill=0 with cmd_valid held high -> second command accepted only after first done; final Q=0010; cmd_ready low throughout busy.
